sa_controller: RTL

SA_CONTROLLER -- requirements
Module: sa_controller

---
 rtl/sa_pkg.sv | 23 ++
 rtl/sa_skew_gen.sv | 32 +++
 rtl/sa_controller.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared types and default sizing for the systolic-array tile controller.
package sa_pkg;

    localparam int SA_N      = 4;
    localparam int SA_ADDR_W = 10;
    localparam int SA_K_W    = 8;

    // The FEED counter must reach k_len + 2*(N-1), so it needs headroom above K_W.
    function automatic int t_width(input int k_w, input int n);
        return k_w + $clog2(n) + 1;
    endfunction

    localparam int SA_T_W = t_width(SA_K_W, SA_N);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sa_state_t;

endpackage

// File: rtl/sa_skew_gen.sv
// Skewed operand-valid mask: row/column i sees its operands i cycles later,
// plus one cycle for the SRAM read latency.
module sa_skew_gen
    import sa_pkg::*;
#(
    parameter int N   = SA_N,
    parameter int K_W = SA_K_W,
    parameter int TW  = SA_T_W
) (
    input  logic [TW-1:0]  t,
    input  logic [K_W-1:0] k_len,
    input  logic           feed,
    output logic [N-1:0]   feed_valid
);

    localparam int CW = TW + 1;

    logic [CW-1:0] t_ext;
    logic [CW-1:0] k_ext;

    assign t_ext = CW'(t);
    assign k_ext = CW'(k_len);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            localparam logic [CW-1:0] LO   = CW'(gi + 1);
            localparam logic [CW-1:0] SKEW = CW'(gi);
            assign feed_valid[gi] = feed && (t_ext >= LO) && (t_ext <= k_ext + SKEW);
        end
    endgenerate

endmodule

// File: rtl/sa_controller.sv
// Tile-job sequencer for an NxN systolic array: clear, skewed operand feed,
// row-by-row result drain. Every output comes straight from a flop.
module sa_controller
    import sa_pkg::*;
#(
    parameter int N      = SA_N,
    parameter int ADDR_W = SA_ADDR_W,
    parameter int K_W    = SA_K_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [K_W-1:0]        k_len,
    input  logic [ADDR_W-1:0]     a_base,
    input  logic [ADDR_W-1:0]     b_base,
    input  logic [ADDR_W-1:0]     c_base,
    output logic                  busy,
    output logic                  done,
    output logic                  pe_clear,
    output logic                  a_rd_en,
    output logic [ADDR_W-1:0]     a_rd_addr,
    output logic                  b_rd_en,
    output logic [ADDR_W-1:0]     b_rd_addr,
    output logic [N-1:0]          feed_valid,
    output logic                  c_wr_en,
    output logic [ADDR_W-1:0]     c_wr_addr,
    output logic [$clog2(N)-1:0]  c_sel
);

    localparam int TW = t_width(K_W, N);
    localparam int RW = $clog2(N);
    localparam logic [TW-1:0] SKEW2  = TW'(2 * (N - 1));
    localparam logic [RW-1:0] R_LAST = RW'(N - 1);

    sa_state_t         state_reg, state_next;
    logic [TW-1:0]     t_reg, t_next;
    logic [RW-1:0]     r_reg, r_next;
    logic [K_W-1:0]    k_reg, k_next;
    logic [ADDR_W-1:0] a_reg, a_next;
    logic [ADDR_W-1:0] b_reg, b_next;
    logic [ADDR_W-1:0] c_reg, c_next;
    logic [TW-1:0]     f_last;

    logic                  busy_next;
    logic                  done_next;
    logic                  pe_clear_next;
    logic                  feed_next;
    logic                  rd_en_next;
    logic [ADDR_W-1:0]     a_rd_addr_next;
    logic [ADDR_W-1:0]     b_rd_addr_next;
    logic [N-1:0]          feed_valid_next;
    logic                  c_wr_en_next;
    logic [ADDR_W-1:0]     c_wr_addr_next;
    logic [RW-1:0]         c_sel_next;

    function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] base,
                                                   input logic [TW-1:0]     off);
        logic [ADDR_W+TW-1:0] sum;
        sum = {{TW{1'b0}}, base} + {{ADDR_W{1'b0}}, off};
        return sum[ADDR_W-1:0];
    endfunction

    assign f_last = TW'(k_reg) + SKEW2;

    always_comb begin
        state_next = state_reg;
        t_next     = t_reg;
        r_next     = r_reg;
        k_next     = k_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        c_next     = c_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    k_next     = k_len;
                    a_next     = a_base;
                    b_next     = b_base;
                    c_next     = c_base;
                    t_next     = '0;
                    r_next     = '0;
                    state_next = (k_len == '0) ? ST_DONE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_FEED;
                    t_next     = '0;
                end
            end
            ST_FEED: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (t_reg == f_last) begin
                    state_next = ST_DRAIN;
                    r_next     = '0;
                end else begin
                    t_next = t_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (r_reg == R_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    r_next = r_reg + 1'b1;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of lag relative to the state they describe.
    sa_skew_gen #(
        .N   (N),
        .K_W (K_W),
        .TW  (TW)
    ) u_skew (
        .t          (t_next),
        .k_len      (k_next),
        .feed       (feed_next),
        .feed_valid (feed_valid_next)
    );

    always_comb begin
        busy_next      = (state_next != ST_IDLE);
        done_next      = (state_next == ST_DONE);
        pe_clear_next  = (state_next == ST_CLEAR);
        feed_next      = (state_next == ST_FEED);
        rd_en_next     = feed_next && (t_next < TW'(k_next));
        a_rd_addr_next = rd_en_next ? addr_add(a_next, t_next) : '0;
        b_rd_addr_next = rd_en_next ? addr_add(b_next, t_next) : '0;
        c_wr_en_next   = (state_next == ST_DRAIN);
        c_wr_addr_next = c_wr_en_next ? addr_add(c_next, TW'(r_next)) : '0;
        c_sel_next     = c_wr_en_next ? r_next : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            t_reg      <= '0;
            r_reg      <= '0;
            k_reg      <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            c_reg      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pe_clear   <= 1'b0;
            a_rd_en    <= 1'b0;
            a_rd_addr  <= '0;
            b_rd_en    <= 1'b0;
            b_rd_addr  <= '0;
            feed_valid <= '0;
            c_wr_en    <= 1'b0;
            c_wr_addr  <= '0;
            c_sel      <= '0;
        end else begin
            state_reg  <= state_next;
            t_reg      <= t_next;
            r_reg      <= r_next;
            k_reg      <= k_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            c_reg      <= c_next;
            busy       <= busy_next;
            done       <= done_next;
            pe_clear   <= pe_clear_next;
            a_rd_en    <= rd_en_next;
            a_rd_addr  <= a_rd_addr_next;
            b_rd_en    <= rd_en_next;
            b_rd_addr  <= b_rd_addr_next;
            feed_valid <= feed_valid_next;
            c_wr_en    <= c_wr_en_next;
            c_wr_addr  <= c_wr_addr_next;
            c_sel      <= c_sel_next;
        end
    end

endmodule
